// File: rtl/updown_mon_pkg.sv
// updown_mon_pkg: shared state/step enums and default widths for the up/down counter monitor
package updown_mon_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERR_W = 8;
  typedef enum logic [1:0] {EMPTY, FIRST, LOCK_UP, LOCK_DN} state_t;
  typedef enum logic [1:0] {STALL, INC, DEC, BAD} step_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/updown_count_monitor.sv
// updown_count_monitor: passive observer that locks onto an up/down count and flags bad steps, wraps and reversals
module updown_count_monitor
  import updown_mon_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ERR_W       = DEF_ERR_W,
  parameter int LOSS_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic             wrap,
  output logic             dir_chg,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_count
);
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t           state;
  step_t            step;
  logic [WIDTH-1:0] prev, delta;
  logic [3:0]       miss;
  logic             bad;
  assign delta      = count_in - prev;
  assign step       = delta == '0 ? STALL : delta == WIDTH'(1) ? INC : delta == MAX ? DEC : BAD;
  assign bad        = sample_en && state != EMPTY && step == BAD;
  assign locked     = state == LOCK_UP || state == LOCK_DN;
  assign last_count = prev;
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .rst  (reset),
    .inc  (bad),
    .count(err_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      dir     <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
      miss    <= '0;
      prev    <= '0;
    end else begin
      err     <= bad;
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
      if (sample_en) begin
        prev <= count_in;
        case (state)
          EMPTY: state <= FIRST;
          FIRST:
            if (step == INC) begin
              state <= LOCK_UP;
              dir   <= 1'b1;
            end else if (step == DEC) begin
              state <= LOCK_DN;
              dir   <= 1'b0;
            end
          default:
            if (step == BAD) begin
              // lock is dropped after LOSS_THRESH consecutive illegal steps
              if (int'(miss) + 1 >= LOSS_THRESH) begin
                state <= FIRST;
                miss  <= '0;
              end else miss <= miss + 4'd1;
            end else begin
              miss <= '0;
              if (step == INC) begin
                wrap <= prev == MAX;
                if (state == LOCK_DN) begin
                  state   <= LOCK_UP;
                  dir     <= 1'b1;
                  dir_chg <= 1'b1;
                end
              end else if (step == DEC) begin
                wrap <= prev == '0;
                if (state == LOCK_UP) begin
                  state   <= LOCK_DN;
                  dir     <= 1'b0;
                  dir_chg <= 1'b1;
                end
              end
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_updown_count_monitor.sv
// tb_updown_count_monitor: table vectors, corner sequences and random stimulus against a reference model
module tb_updown_count_monitor;
  localparam int W = 4, EW = 8, LT = 2;
  logic clk = 1'b0, reset = 1'b1, sample_en = 1'b0;
  logic [W-1:0] count_in = '0;
  logic locked, dir, err, wrap, dir_chg;
  logic [EW-1:0] err_count;
  logic [W-1:0] last_count;
  int n_chk = 0, n_fail = 0;
  int m_phase, m_dir, m_prev, m_miss, m_ec, m_err, m_wrap, m_dc;
  typedef struct {
    logic rst, en;
    logic [3:0] c;
    logic l, d, e, w, dc;
    int ec, last;
  } vec_t;
  vec_t tv[$];

  updown_count_monitor #(.WIDTH(W), .ERR_W(EW), .LOSS_THRESH(LT)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .count_in  (count_in),
    .locked    (locked),
    .dir       (dir),
    .err       (err),
    .wrap      (wrap),
    .dir_chg   (dir_chg),
    .err_count (err_count),
    .last_count(last_count)
  );

  always #5 clk = ~clk;

  // model: phase 0 = nothing seen, 1 = one sample seen, 2 = locked
  function automatic void model(input bit r, input bit e, input int c);
    int d;
    m_err = 0; m_wrap = 0; m_dc = 0;
    if (r) begin
      m_phase = 0; m_dir = 0; m_prev = 0; m_miss = 0; m_ec = 0;
      return;
    end
    if (!e) return;
    d = (c - m_prev + 16) % 16;
    if (m_phase == 0) m_phase = 1;
    else if (d != 0 && d != 1 && d != 15) begin
      m_err = 1;
      if (m_ec < 255) m_ec++;
      if (m_phase == 2) begin
        m_miss++;
        if (m_miss == LT) begin m_phase = 1; m_miss = 0; end
      end
    end else begin
      m_miss = 0;
      if (d != 0) begin
        if (m_phase == 2) begin
          m_wrap = (d == 1) ? (m_prev == 15) : (m_prev == 0);
          m_dc = (m_dir != (d == 1));
        end
        m_phase = 2;
        m_dir = (d == 1);
      end
    end
    m_prev = c;
  endfunction

  task automatic check(input string n, input logic [15:0] a, input logic [15:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic [3:0] c);
    reset = r; sample_en = e; count_in = c;
    @(posedge clk);
    model(r, e, int'(c));
    @(negedge clk);
  endtask

  task automatic check_model(input string t);
    check({t, ".locked"}, 16'(locked), 16'(m_phase == 2));
    check({t, ".dir"}, 16'(dir), 16'(m_dir));
    check({t, ".err"}, 16'(err), 16'(m_err));
    check({t, ".wrap"}, 16'(wrap), 16'(m_wrap));
    check({t, ".dir_chg"}, 16'(dir_chg), 16'(m_dc));
    check({t, ".err_count"}, 16'(err_count), 16'(m_ec));
    check({t, ".last_count"}, 16'(last_count), 16'(m_prev));
  endtask

  task automatic add(input logic r, e, input logic [3:0] c, input logic l, d, er, w, dc, input int ec, last);
    tv.push_back('{r, e, c, l, d, er, w, dc, ec, last});
  endtask

  initial begin
    //  rst en  c  L  d  e  w dc ec last
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1,  2, 1, 1, 0, 0, 0, 0, 2);
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 13, 0, 0, 0, 0, 0, 0, 13);
    add(0, 1, 14, 1, 1, 0, 0, 0, 0, 14);
    add(0, 1, 15, 1, 1, 0, 0, 0, 0, 15);
    add(0, 1,  0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1,  1, 1, 1, 0, 0, 0, 0, 1);
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 1,  5, 1, 1, 0, 0, 0, 0, 5);
    add(0, 1,  6, 1, 1, 0, 0, 0, 0, 6);
    add(0, 1,  5, 1, 0, 0, 0, 1, 0, 5);
    add(0, 1,  4, 1, 0, 0, 0, 0, 0, 4);
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  2, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1,  3, 1, 1, 0, 0, 0, 0, 3);
    add(0, 1,  4, 1, 1, 0, 0, 0, 0, 4);
    add(0, 1,  9, 1, 1, 1, 0, 0, 1, 9);
    add(0, 1, 12, 0, 1, 1, 0, 0, 2, 12);
    add(0, 1, 13, 1, 1, 0, 0, 0, 2, 13);
    add(0, 1, 14, 1, 1, 0, 0, 0, 2, 14);
    add(0, 1, 15, 1, 1, 0, 0, 0, 2, 15);
    add(0, 1,  0, 1, 1, 0, 1, 0, 2, 0);
    add(0, 1, 15, 1, 0, 0, 1, 1, 2, 15);
    add(0, 1, 15, 1, 0, 0, 0, 0, 2, 15);
    add(0, 0,  3, 1, 0, 0, 0, 0, 2, 15);
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  5, 0, 0, 0, 0, 0, 0, 5);
    add(0, 1,  9, 0, 0, 1, 0, 0, 1, 9);
    add(0, 1,  9, 0, 0, 0, 0, 0, 1, 9);
    add(0, 1,  8, 1, 0, 0, 0, 0, 1, 8);
    add(1, 1,  4, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  6, 0, 0, 0, 0, 0, 0, 6);
    @(negedge clk);
    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].en, tv[i].c);
      check($sformatf("row%0d.locked", i), 16'(locked), 16'(tv[i].l));
      check($sformatf("row%0d.dir", i), 16'(dir), 16'(tv[i].d));
      check($sformatf("row%0d.err", i), 16'(err), 16'(tv[i].e));
      check($sformatf("row%0d.wrap", i), 16'(wrap), 16'(tv[i].w));
      check($sformatf("row%0d.dir_chg", i), 16'(dir_chg), 16'(tv[i].dc));
      check($sformatf("row%0d.err_count", i), 16'(err_count), 16'(tv[i].ec));
      check($sformatf("row%0d.last_count", i), 16'(last_count), 16'(tv[i].last));
    end
    // stall then idle: state and last_count must hold while sample_en is low
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 7);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 4'($urandom_range(0, 15)));
      check("idle.pulses", 16'({err, wrap, dir_chg}), 16'(0));
      check("idle.last_count", 16'(last_count), 16'(7));
      check("idle.locked", 16'(locked), 16'(0));
    end
    tick(0, 1, 8);
    check("idle.relock", 16'(locked), 16'(1));
    check("idle.dir", 16'(dir), 16'(1));
    // error counter saturation, then reset beats a simultaneous sample
    tick(1, 0, 0);
    for (int i = 0; i < 300; i++) tick(0, 1, (i % 2) ? 4'd8 : 4'd0);
    check("sat.err_count", 16'(err_count), 16'(255));
    check("sat.err", 16'(err), 16'(1));
    check_model("sat");
    tick(1, 1, 5);
    check("rst.outputs", 16'({locked, dir, err, wrap, dir_chg}), 16'(0));
    check("rst.err_count", 16'(err_count), 16'(0));
    check("rst.last_count", 16'(last_count), 16'(0));
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [3:0] c;
      k = $urandom_range(0, 9);
      c = k < 3 ? 4'(m_prev) : k < 6 ? 4'(m_prev + 1) : k < 9 ? 4'(m_prev + 15) : 4'($urandom_range(0, 15));
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, c);
      check_model($sformatf("rnd%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
